// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: redirect kind
// encodings, fetch-sequencing FSM states and the instruction size.
package pc_pkg;

    // Redirect source encodings carried on redirect_kind
    localparam logic [1:0] REDIR_BRANCH = 2'b00;
    localparam logic [1:0] REDIR_JALR   = 2'b01;
    localparam logic [1:0] REDIR_TRAP   = 2'b10;
    localparam logic [1:0] REDIR_RETURN = 2'b11;

    // Fetch sequencing states; BOOT and FLUSH are the single bubble cycles
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pc_state_e;

    // Sequential fetch step in bytes
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: DEPTH circular entries, a write pointer and a
// saturating occupancy count. A push when full overwrites the oldest entry.
// Push and pop in the same cycle replaces the current top in place.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW:0]     count;
    logic [PW-1:0]   top_idx;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);

    // Stack storage, pointer and occupancy update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && pop) begin
            mem[top_idx] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (count != (PW+1)'(DEPTH)) begin
                count <= count + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: owns the fetch PC, picks the next PC from
// sequential / branch / JALR / trap / return sources, rejects misaligned
// targets and inserts one bubble after every accepted redirect.
// Optional return-address stack is built when PC_RAS_EN is defined.
//
// Handshake: pc is offered to fetch while fetch_valid=1; it is consumed on a
// rising edge where fetch_valid=1 and fetch_ready=1, and pc holds while
// fetch_valid=1 and fetch_ready=0. A valid redirect overrides the handshake.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_kind,
    input  logic [XLEN-1:0] imm_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            is_call,
    input  logic [XLEN-1:0] link_addr,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr,
    output logic [1:0]      dbg_state
);
    localparam logic [XLEN-1:0] CLR_BIT0 = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] CLR_LOW2 = {{(XLEN-2){1'b1}}, 2'b00};

    pc_state_e       state;
    pc_state_e       state_next;
    logic [XLEN-1:0] target;
    logic            check_align;
    logic            misaligned;
    logic            take;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

`ifdef PC_RAS_EN
    logic ras_push;
    logic ras_pop;

    // Calls push the link address; returns pop only when something is stored
    assign ras_push = take && is_call;
    assign ras_pop  = take && (redirect_kind == REDIR_RETURN) && !ras_empty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_addr),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras_inputs;

    // Without a stack, returns always take the JALR path and call info is dropped
    assign ras_top           = '0;
    assign ras_empty         = 1'b1;
    assign unused_ras_inputs = ^{is_call, link_addr, ras_top};
`endif

    // Redirect target selection and alignment check
    always_comb begin
        target      = jalr_target & CLR_BIT0;
        check_align = 1'b1;
        case (redirect_kind)
            REDIR_BRANCH: target = imm_target;
            REDIR_JALR:   target = jalr_target & CLR_BIT0;
            REDIR_TRAP: begin
                target      = trap_vec & CLR_LOW2;
                check_align = 1'b0;
            end
            REDIR_RETURN: target = ras_empty ? (jalr_target & CLR_BIT0) : ras_top;
            default:      target = jalr_target & CLR_BIT0;
        endcase
    end

    assign misaligned = redirect_valid && check_align && target[1];
    assign take       = redirect_valid && !misaligned;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: accepted redirect forces a bubble, rejected one freezes
    always_comb begin
        state_next = state;
        if (take) begin
            state_next = FLUSH;
        end else if (!misaligned) begin
            case (state)
                BOOT:    state_next = RUN;
                RUN:     state_next = RUN;
                FLUSH:   state_next = RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    // FSM outputs: pc is only offered in RUN
    always_comb begin
        fetch_valid = (state == RUN);
        dbg_state   = state;
    end

    // PC register: redirect first, then sequential advance on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VEC;
        end else if (take) begin
            pc <= target;
        end else if (!misaligned && (state == RUN) && fetch_ready) begin
            pc <= pc + XLEN'(INSTR_BYTES);
        end
    end

    // Misalignment report: one-cycle pulse, address held until the next error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_err <= misaligned;
            if (misaligned) begin
                misalign_addr <= target;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen. Covers the PC_RAS_EN build when the macro
// is defined and the plain build otherwise.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int W     = 2 * XLEN + 2;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            fetch_valid;
    logic            fetch_ready = 1'b1;
    logic [XLEN-1:0] pc;
    logic            redirect_valid = 1'b0;
    logic [1:0]      redirect_kind = 2'b00;
    logic [XLEN-1:0] imm_target = '0;
    logic [XLEN-1:0] jalr_target = '0;
    logic [XLEN-1:0] trap_vec = '0;
    logic            is_call = 1'b0;
    logic [XLEN-1:0] link_addr = '0;
    logic            misalign_err;
    logic [XLEN-1:0] misalign_addr;
    logic [1:0]      dbg_state;

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_VEC (32'h0000_0000),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .imm_target     (imm_target),
        .jalr_target    (jalr_target),
        .trap_vec       (trap_vec),
        .is_call        (is_call),
        .link_addr      (link_addr),
        .misalign_err   (misalign_err),
        .misalign_addr  (misalign_addr),
        .dbg_state      (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: the PC, whether it is currently offered, the error
    // report, and the return stack as a plain list (newest at the back).
    logic [XLEN-1:0] m_pc;
    logic            m_fv;
    logic            m_err;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_ras[$];
    logic [W-1:0]    exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        logic [XLEN-1:0] t;
        logic            aligned_rule;
        logic            from_ras;
        if (!rst_n) begin
            m_pc   = '0;
            m_fv   = 1'b0;
            m_err  = 1'b0;
            m_addr = '0;
            m_ras.delete();
            exp_q.delete();
        end else if (redirect_valid) begin
            aligned_rule = 1'b1;
            from_ras     = 1'b0;
            case (redirect_kind)
                2'b00: t = imm_target;
                2'b10: begin
                    t = {trap_vec[XLEN-1:2], 2'b00};
                    aligned_rule = 1'b0;
                end
                2'b11: begin
                    if (RAS_ON && m_ras.size() > 0) begin
                        t = m_ras[m_ras.size()-1];
                        from_ras = 1'b1;
                    end else begin
                        t = {jalr_target[XLEN-1:1], 1'b0};
                    end
                end
                default: t = {jalr_target[XLEN-1:1], 1'b0};
            endcase
            if (aligned_rule && t[1]) begin
                m_err  = 1'b1;
                m_addr = t;
            end else begin
                m_err = 1'b0;
                if (from_ras) void'(m_ras.pop_back());
                if (RAS_ON && is_call) begin
                    m_ras.push_back(link_addr);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
                m_pc = t;
                m_fv = 1'b0;
            end
        end else begin
            m_err = 1'b0;
            if (!m_fv) m_fv = 1'b1;
            else if (fetch_ready) m_pc = m_pc + 32'd4;
        end
        exp_q.push_back({m_pc, m_fv, m_err, m_addr});
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (chk_en) begin
                check("sb_pc", pc, e[W-1 -: XLEN]);
                check("sb_fetch_valid", {31'd0, fetch_valid}, {31'd0, e[XLEN+1]});
                check("sb_misalign_err", {31'd0, misalign_err}, {31'd0, e[XLEN]});
                check("sb_misalign_addr", misalign_addr, e[XLEN-1:0]);
            end
        end else if (chk_en) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got no expectation, expected one at %0t", $time);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one redirect, step through the bubble, leave pc offered
    task automatic redirect(input logic [1:0] kind, input logic [XLEN-1:0] imm,
                            input logic [XLEN-1:0] jalr, input logic call,
                            input logic [XLEN-1:0] link);
        redirect_valid = 1'b1;
        redirect_kind  = kind;
        imm_target     = imm;
        jalr_target    = jalr;
        is_call        = call;
        link_addr      = link;
        tick();
        redirect_valid = 1'b0;
        is_call        = 1'b0;
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [XLEN-1:0] ret_exp [5];
        repeat (3) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // boot bubble then sequential fetch
        check("boot_fv", {31'd0, fetch_valid}, 32'd0);
        check("boot_pc", pc, 32'h0);
        check("boot_state", {30'd0, dbg_state}, 32'd0);
        tick(); check("run0_fv", {31'd0, fetch_valid}, 32'd1); check("run0_pc", pc, 32'h0);
        tick(); check("run1_pc", pc, 32'h4);
        tick(); check("run2_pc", pc, 32'h8);

        // stall at 0x8
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 32'h8);
            check("stall_fv", {31'd0, fetch_valid}, 32'd1);
        end
        fetch_ready = 1'b1;
        tick(); check("resume_pc", pc, 32'hC);

        // JALR redirect clears bit 0, one bubble
        redirect_valid = 1'b1; redirect_kind = 2'b01; jalr_target = 32'h101;
        tick();
        check("jalr_pc", pc, 32'h100);
        check("jalr_bubble", {31'd0, fetch_valid}, 32'd0);
        check("jalr_state", {30'd0, dbg_state}, 32'd2);
        redirect_valid = 1'b0;
        tick(); check("jalr_pc1", pc, 32'h100); check("jalr_fv1", {31'd0, fetch_valid}, 32'd1);
        tick(); check("jalr_pc2", pc, 32'h104);

        // misaligned branch target rejected
        redirect_valid = 1'b1; redirect_kind = 2'b00; imm_target = 32'h102;
        tick();
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_addr", misalign_addr, 32'h102);
        check("mis_pc", pc, 32'h104);
        redirect_valid = 1'b0;
        tick();
        check("mis_err_clr", {31'd0, misalign_err}, 32'd0);
        check("mis_addr_hold", misalign_addr, 32'h102);
        check("mis_pc_next", pc, 32'h108);

        // wrap-around
        redirect(2'b00, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h0);
        check("wrap_pc0", pc, 32'hFFFF_FFF8);
        tick(); check("wrap_pc1", pc, 32'hFFFF_FFFC);
        tick(); check("wrap_pc2", pc, 32'h0);

        // trap clears low bits, never misaligned
        redirect_valid = 1'b1; redirect_kind = 2'b10; trap_vec = 32'h8000_0003;
        tick();
        check("trap_pc", pc, 32'h8000_0000);
        check("trap_err", {31'd0, misalign_err}, 32'd0);
        redirect_valid = 1'b0;
        tick();

        // redirect wins over a stall
        fetch_ready = 1'b0;
        redirect(2'b00, 32'h400, 32'h0, 1'b0, 32'h0);
        check("stall_redir_pc", pc, 32'h400);
        tick(); check("stall_redir_hold", pc, 32'h400);
        fetch_ready = 1'b1;

        // asynchronous reset mid-operation, then redirect during BOOT
        rst_n = 1'b0;
        #1;
        check("areset_pc", pc, 32'h0);
        check("areset_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        redirect_valid = 1'b1; redirect_kind = 2'b00; imm_target = 32'h200;
        rst_n = 1'b1;
        tick();
        check("boot_redir_pc", pc, 32'h200);
        check("boot_redir_fv", {31'd0, fetch_valid}, 32'd0);
        redirect_valid = 1'b0;
        tick(); check("boot_redir_fv1", {31'd0, fetch_valid}, 32'd1);

`ifdef PC_RAS_EN
        // five calls overflow a four-deep stack
        for (int i = 0; i < 5; i++) begin
            redirect(2'b00, 32'h1000 + 32'(i) * 32'h100, 32'h0, 1'b1, 32'(i + 1) * 32'h10);
        end
        ret_exp = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h300};
        for (int i = 0; i < 5; i++) begin
            redirect(2'b11, 32'h0, 32'h301, 1'b0, 32'h0);
            check("ras_ret", pc, ret_exp[i]);
        end

        // return-and-call replaces the top
        for (int i = 0; i < 4; i++) begin
            redirect(2'b00, 32'h2000 + 32'(i) * 32'h100, 32'h0, 1'b1, 32'(i + 1) * 32'h10);
        end
        redirect(2'b11, 32'h0, 32'h301, 1'b1, 32'h90);
        check("ras_swap_pc", pc, 32'h40);
        ret_exp = '{32'h90, 32'h30, 32'h20, 32'h10, 32'h300};
        for (int i = 0; i < 5; i++) begin
            redirect(2'b11, 32'h0, 32'h301, 1'b0, 32'h0);
            check("ras_swap_ret", pc, ret_exp[i]);
        end
`else
        ret_exp = '{32'h554, 32'h600, 32'h0, 32'h0, 32'h0};
        redirect(2'b11, 32'h0, 32'h555, 1'b1, 32'h90);
        check("ret_norас_pc", pc, ret_exp[0]);
        redirect(2'b11, 32'h0, 32'h601, 1'b0, 32'h0);
        check("ret_noras_pc2", pc, ret_exp[1]);
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator. It owns the PC register, selects the next PC from sequential, branch/JAL, JALR, trap and return sources, and presents the PC to fetch over a valid/ready handshake.
- It checks redirect targets for misalignment and inserts one bubble after every redirect.
- It sits between the decode/execute redirect logic and the instruction-memory fetch stage.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2; used only with PC_RAS_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- fetch_valid  out  1  pc is valid for fetch.
- fetch_ready  in  1  fetch accepts pc this cycle.
- pc  out  XLEN  current fetch PC.
- redirect_valid  in  1  redirect request this cycle.
- redirect_kind  in  2  00 branch/JAL, 01 JALR, 10 trap, 11 return.
- imm_target  in  XLEN  PC+imm target.
- jalr_target  in  XLEN  rs1+imm, unmasked.
- trap_vec  in  XLEN  trap handler address.
- is_call  in  1  with redirect_valid, push link_addr.
- link_addr  in  XLEN  return address to push.
- misalign_err  out  1  one-cycle pulse: rejected misaligned target.
- misalign_addr  out  XLEN  offending target, held until the next error.

Behaviour:
- Reset is asynchronous on rst_n low: pc=RESET_VEC, fetch_valid=0, misalign_err=0, misalign_addr=0, RAS empty, state=BOOT.
- States:
  - BOOT: fetch_valid=0 for exactly one cycle, then go to RUN.
  - RUN: fetch_valid=1.
  - FLUSH: fetch_valid=0 for one cycle, then go to RUN.
- Target per kind:
  - 00: imm_target.
  - 01: jalr_target with bit 0 cleared.
  - 10: trap_vec with bits 1:0 cleared; never misaligned.
  - 11: with PC_RAS_EN and RAS non-empty, the popped RAS top; otherwise the kind 01 rule.
- Misalignment: target bit 1 set (kinds 00, 01, 11). Result: pc unchanged, misalign_err=1 next cycle, misalign_addr=target, no RAS push/pop, state unchanged.
- Valid redirect in any state:
  - pc=target at the next edge; state=FLUSH.
  - Redirect takes priority over the handshake; fetch_ready is ignored that cycle.
- No redirect, RUN, fetch_ready=1: pc=pc+4, modulo 2^XLEN (wraps to 0 from all-ones minus 3).
- No redirect, RUN, fetch_ready=0: pc and fetch_valid held (stall). pc must not change while fetch_valid=1 and fetch_ready=0, except on redirect.
- Redirect during BOOT: accepted; BOOT ends and FLUSH follows.
- Reset mid-operation: all state returns to reset values immediately; no partial RAS update survives.
- Latency: redirect sampled at edge N → new pc visible after N; fetch_valid=1 from edge N+1.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: a RAS of RAS_DEPTH x XLEN circular entries, with a pointer and a saturating count.
  - Push on a valid, aligned redirect with is_call=1.
  - Pop on kind 11.
  - Kind 11 with is_call=1: pop first, then push link_addr into the freed slot; count unchanged.
  - Push when full: overwrite the oldest entry; count stays RAS_DEPTH.
  - Pop when empty: fall back to jalr_target; count stays 0.
  - Misaligned redirects leave the RAS untouched.
- Undefined: no RAS storage. Kind 11 behaves exactly as kind 01; is_call is ignored.

Decomposition:
- Shared package pc_pkg:
  - Redirect kind encodings (REDIR_BRANCH, REDIR_JALR, REDIR_TRAP, REDIR_RETURN).
  - FSM state enum (BOOT, RUN, FLUSH).
  - Constant INSTR_BYTES=4.
- One sub-module: pc_ras, the RAS with push/pop/count, instantiated only under PC_RAS_EN.

Test Plan:
- Reset release, fetch_ready=1 → cycle 0 fetch_valid=0, then pc 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- fetch_ready=0 for 3 cycles at pc=0x8 → pc stays 0x8, fetch_valid=1; resume → 0xC.
- Redirect kind 01, jalr_target=0x101 → next pc=0x100, fetch_valid=0 for one cycle, then 0x100, 0x104. Kind 00 with imm_target=0x102 → misalign_err pulse, misalign_addr=0x102, pc unchanged.
- Wrap-around: XLEN=32, pc=0xFFFF_FFFC, fetch_ready=1 → pc=0x0. Redirect kind 10, trap_vec=0x8000_0003 → pc=0x8000_0000.
- PC_RAS_EN, RAS_DEPTH=4: 5 calls with link 0x10..0x50, then 5 returns → targets 0x50, 0x40, 0x30, 0x20, then jalr fallback (0x10 overwritten).
- PC_RAS_EN: kind 11 with is_call=1, RAS top 0x40, link 0x90 → pc=0x40, RAS top becomes 0x90, count unchanged. With the macro undefined, the same stimulus → pc=jalr_target & ~1.
